// File: rtl/array_feeder.sv
// array_feeder: host-side sequencer for processing_array. Buffers the A columns and
// B rows of one job, streams them into the array, drains it, reads the result back
// and hands it to the host through a ready/valid result port.
module array_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int N          = 2,
    parameter int K_MAX      = 16,
    parameter int PIPE_LAT   = 3,
    parameter int READ_LAT   = 1
) (
    input  logic                            clk,
    input  logic                            i_reset,
    input  logic                            i_wr_en,
    input  logic                            i_wr_sel,
    input  logic [$clog2(K_MAX)-1:0]        i_wr_addr,
    input  logic [N*DATA_WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(K_MAX):0]          i_k_len,
    input  logic                            i_start,
    output logic                            o_busy,
    output logic [N*DATA_WIDTH-1:0]         o_a_vector,
    output logic [N*DATA_WIDTH-1:0]         o_b_vector,
    output logic                            o_data_valid,
    output logic                            o_read_en,
    output logic                            o_pa_reset,
    input  logic [N*N*ACC_WIDTH-1:0]        i_c_matrix,
    input  logic                            i_saturate_detect,
    output logic [N*N*ACC_WIDTH-1:0]        o_result,
    output logic                            o_saturate,
    output logic                            o_result_valid,
    input  logic                            i_result_ready
);

    localparam int ADDR_W = $clog2(K_MAX);
    localparam int KLEN_W = ADDR_W + 1;
    localparam int VEC_W  = N * DATA_WIDTH;
    localparam int CNT_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        READ,
        CAPTURE,
        HOLD
    } state_t;

    state_t              state;
    logic [VEC_W-1:0]    a_buf [K_MAX];
    logic [VEC_W-1:0]    b_buf [K_MAX];
    logic [KLEN_W-1:0]   k_len;
    logic [KLEN_W-1:0]   k_idx;
    logic [CNT_W-1:0]    lat_cnt;
    logic                addr_ok;
    logic                start_ok;
    logic                sample_sat;

    // When the buffer depth fills the whole address space every address is legal
    if ((1 << ADDR_W) == K_MAX) begin : g_addr_full
        assign addr_ok = 1'b1;
    end else begin : g_addr_partial
        assign addr_ok = ({1'b0, i_wr_addr} < KLEN_W'(K_MAX));
    end

    assign start_ok   = i_start && (state == IDLE) && (i_k_len != '0) &&
                        (i_k_len <= KLEN_W'(K_MAX));
    assign sample_sat = (state == STREAM) || (state == DRAIN) ||
                        (state == READ)   || (state == CAPTURE);
    assign o_pa_reset = i_reset || (state == CLEAR);
    assign o_busy     = (state != IDLE);

    // Operand buffers only take host writes while idle so a running job sees frozen data
    always_ff @(posedge clk) begin
        if (!i_reset && i_wr_en && (state == IDLE) && addr_ok) begin
            if (i_wr_sel) begin
                b_buf[i_wr_addr] <= i_wr_data;
            end else begin
                a_buf[i_wr_addr] <= i_wr_data;
            end
        end
    end

    // Job sequencer with registered array-side and host-side outputs
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state          <= IDLE;
            k_len          <= '0;
            k_idx          <= '0;
            lat_cnt        <= '0;
            o_a_vector     <= '0;
            o_b_vector     <= '0;
            o_data_valid   <= 1'b0;
            o_read_en      <= 1'b0;
            o_result       <= '0;
            o_saturate     <= 1'b0;
            o_result_valid <= 1'b0;
        end else begin
            if (sample_sat && i_saturate_detect) begin
                o_saturate <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state      <= CLEAR;
                        k_len      <= i_k_len;
                        o_saturate <= 1'b0;
                    end
                end
                CLEAR: begin
                    state        <= STREAM;
                    o_a_vector   <= a_buf[ADDR_W'(0)];
                    o_b_vector   <= b_buf[ADDR_W'(0)];
                    o_data_valid <= 1'b1;
                    k_idx        <= KLEN_W'(1);
                end
                STREAM: begin
                    if (k_idx == k_len) begin
                        state        <= DRAIN;
                        o_a_vector   <= '0;
                        o_b_vector   <= '0;
                        o_data_valid <= 1'b0;
                        lat_cnt      <= '0;
                    end else begin
                        o_a_vector <= a_buf[k_idx[ADDR_W-1:0]];
                        o_b_vector <= b_buf[k_idx[ADDR_W-1:0]];
                        k_idx      <= k_idx + 1'b1;
                    end
                end
                DRAIN: begin
                    if (lat_cnt == CNT_W'(PIPE_LAT - 1)) begin
                        state     <= READ;
                        o_read_en <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                READ: begin
                    state     <= CAPTURE;
                    o_read_en <= 1'b0;
                    lat_cnt   <= '0;
                end
                CAPTURE: begin
                    if (lat_cnt == CNT_W'(READ_LAT - 1)) begin
                        state          <= HOLD;
                        o_result       <= i_c_matrix;
                        o_result_valid <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (i_result_ready) begin
                        state          <= IDLE;
                        o_result_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array_feeder.sv
// tb_array_feeder: drives array_feeder against a behavioural saturating array and
// scores each captured result against a software matrix product.
module tb_array_feeder;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int N  = 2;
    localparam int KM = 16;
    localparam int PL = 3;
    localparam int RL = 1;

    logic               clk = 1'b0;
    logic               i_reset = 1'b1;
    logic               i_wr_en = 1'b0;
    logic               i_wr_sel = 1'b0;
    logic [3:0]         i_wr_addr = '0;
    logic [15:0]        i_wr_data = '0;
    logic [4:0]         i_k_len = '0;
    logic               i_start = 1'b0;
    logic               o_busy;
    logic [15:0]        o_a_vector;
    logic [15:0]        o_b_vector;
    logic               o_data_valid;
    logic               o_read_en;
    logic               o_pa_reset;
    logic [63:0]        pa_c = '0;
    logic               pa_sat = 1'b0;
    logic [63:0]        o_result;
    logic               o_saturate;
    logic               o_result_valid;
    logic               i_result_ready = 1'b0;

    typedef struct {
        logic [63:0] result;
        logic        sat;
    } exp_t;

    exp_t               sb_q[$];
    int                 compared = 0;
    int                 mismatched = 0;
    logic signed [7:0]  mat_a [2][16];
    logic signed [7:0]  mat_b [16][2];
    logic signed [15:0] pa_acc [2][2];

    array_feeder #(
        .DATA_WIDTH(DW), .ACC_WIDTH(AW), .N(N), .K_MAX(KM), .PIPE_LAT(PL), .READ_LAT(RL)
    ) dut (
        .clk(clk), .i_reset(i_reset), .i_wr_en(i_wr_en), .i_wr_sel(i_wr_sel),
        .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .i_k_len(i_k_len),
        .i_start(i_start), .o_busy(o_busy), .o_a_vector(o_a_vector),
        .o_b_vector(o_b_vector), .o_data_valid(o_data_valid), .o_read_en(o_read_en),
        .o_pa_reset(o_pa_reset), .i_c_matrix(pa_c), .i_saturate_detect(pa_sat),
        .o_result(o_result), .o_saturate(o_saturate), .o_result_valid(o_result_valid),
        .i_result_ready(i_result_ready)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Behavioural processing_array: saturating MAC per PE, result readable one cycle after read_en
    always @(posedge clk) begin
        int  sum;
        bit  sat_now;
        sat_now = 1'b0;
        if (o_pa_reset) begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++)
                    pa_acc[i][j] <= '0;
        end else begin
            if (o_data_valid) begin
                for (int i = 0; i < 2; i++) begin
                    for (int j = 0; j < 2; j++) begin
                        sum = int'(pa_acc[i][j]) +
                              int'($signed(o_a_vector[i*8 +: 8])) * int'($signed(o_b_vector[j*8 +: 8]));
                        if (sum > 32767) begin
                            sum = 32767;
                            sat_now = 1'b1;
                        end else if (sum < -32768) begin
                            sum = -32768;
                            sat_now = 1'b1;
                        end
                        pa_acc[i][j] <= 16'(sum);
                    end
                end
            end
            if (o_read_en) begin
                for (int i = 0; i < 2; i++)
                    for (int j = 0; j < 2; j++)
                        pa_c[(i*2+j)*16 +: 16] <= pa_acc[i][j];
            end
        end
        pa_sat <= sat_now;
    end

    // Global time limit so a stuck design still ends the run
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic exp_t modelJob(input int k_len);
        exp_t e;
        int   acc;
        e.result = '0;
        e.sat    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                acc = 0;
                for (int k = 0; k < k_len; k++) begin
                    acc = acc + int'(mat_a[i][k]) * int'(mat_b[k][j]);
                    if (acc > 32767) begin
                        acc = 32767;
                        e.sat = 1'b1;
                    end else if (acc < -32768) begin
                        acc = -32768;
                        e.sat = 1'b1;
                    end
                end
                e.result[(i*2+j)*16 +: 16] = 16'(acc);
            end
        end
        return e;
    endfunction

    task automatic clearMats();
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 2; i++) begin
                mat_a[i][k] = '0;
                mat_b[k][i] = '0;
            end
        end
    endtask

    task automatic fillRandom();
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 2; i++) begin
                mat_a[i][k] = 8'($urandom);
                mat_b[k][i] = 8'($urandom);
            end
        end
    endtask

    task automatic writeOperands(input int k_len);
        for (int k = 0; k < k_len; k++) begin
            @(negedge clk);
            i_wr_en = 1'b1; i_wr_sel = 1'b0; i_wr_addr = 4'(k);
            i_wr_data = {mat_a[1][k], mat_a[0][k]};
            @(negedge clk);
            i_wr_sel = 1'b1;
            i_wr_data = {mat_b[k][1], mat_b[k][0]};
        end
        @(negedge clk);
        i_wr_en = 1'b0;
    endtask

    // One full job: optional operand load, start, stream/latency checks, optional backpressure
    task automatic applyStimulus(input int k_len, input bit do_write, input int ready_delay,
                                 input bit busy_noise);
        int          cycles;
        int          dv_cnt;
        int          rd_cnt;
        exp_t        e;
        logic [63:0] snap_res;
        logic        snap_sat;
        if (do_write) writeOperands(k_len);
        @(negedge clk);
        i_k_len = 5'(k_len);
        i_start = 1'b1;
        sb_q.push_back(modelJob(k_len));
        @(negedge clk);
        i_start = 1'b0;
        checkOutput("busy_after_start", 64'(o_busy), 64'd1);
        checkOutput("pa_reset_in_clear", 64'(o_pa_reset), 64'd1);
        cycles = 0; dv_cnt = 0; rd_cnt = 0;
        while (!o_result_valid && cycles < 200) begin
            if (o_data_valid) begin
                if (dv_cnt < 16) begin
                    checkOutput("a_vector", 64'(o_a_vector), 64'({mat_a[1][dv_cnt], mat_a[0][dv_cnt]}));
                    checkOutput("b_vector", 64'(o_b_vector), 64'({mat_b[dv_cnt][1], mat_b[dv_cnt][0]}));
                end
                dv_cnt++;
            end
            if (o_read_en) rd_cnt++;
            if (busy_noise && cycles == 2) begin
                i_start = 1'b1; i_k_len = 5'd3;
                i_wr_en = 1'b1; i_wr_sel = 1'b0; i_wr_addr = 4'd0; i_wr_data = 16'h7f7f;
            end else begin
                i_start = 1'b0;
                i_wr_en = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        i_start = 1'b0;
        i_wr_en = 1'b0;
        if (!o_result_valid) begin
            checkOutput("result_valid_timeout", 64'd0, 64'd1);
            void'(sb_q.pop_front());
            return;
        end
        checkOutput("latency", 64'(cycles), 64'(k_len + PL + RL + 2));
        checkOutput("data_valid_cycles", 64'(dv_cnt), 64'(k_len));
        checkOutput("read_en_pulses", 64'(rd_cnt), 64'd1);
        snap_res = o_result;
        snap_sat = o_saturate;
        repeat (ready_delay) begin
            @(negedge clk);
            checkOutput("hold_valid", 64'(o_result_valid), 64'd1);
            checkOutput("hold_result_stable", o_result, snap_res);
            checkOutput("hold_sat_stable", 64'(o_saturate), 64'(snap_sat));
        end
        i_result_ready = 1'b1;
        if (busy_noise) begin
            i_start = 1'b1;
            i_k_len = 5'd2;
        end
        e = sb_q.pop_front();
        checkOutput("result", o_result, e.result);
        checkOutput("saturate", 64'(o_saturate), 64'(e.sat));
        @(negedge clk);
        i_result_ready = 1'b0;
        i_start = 1'b0;
        checkOutput("valid_drop", 64'(o_result_valid), 64'd0);
        checkOutput("busy_after_handoff", 64'(o_busy), 64'd0);
    endtask

    task automatic applyIllegalStart(input int k_len);
        @(negedge clk);
        i_k_len = 5'(k_len);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        checkOutput($sformatf("illegal_busy_k%0d", k_len), 64'(o_busy), 64'd0);
        checkOutput($sformatf("illegal_pa_reset_k%0d", k_len), 64'(o_pa_reset), 64'd0);
        @(negedge clk);
        checkOutput($sformatf("illegal_dv_k%0d", k_len), 64'(o_data_valid), 64'd0);
    endtask

    // Reset in the third streaming cycle of an 8-deep job; the job must vanish
    task automatic applyAbort();
        int dv_cnt;
        int cycles;
        int valid_seen;
        writeOperands(8);
        @(negedge clk);
        i_k_len = 5'd8;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        dv_cnt = 0; cycles = 0;
        while (dv_cnt < 3 && cycles < 50) begin
            if (o_data_valid) dv_cnt++;
            if (dv_cnt < 3) begin
                @(negedge clk);
                cycles++;
            end
        end
        checkOutput("abort_reached_stream", 64'(dv_cnt), 64'd3);
        i_reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", 64'(o_busy), 64'd0);
        checkOutput("abort_dv", 64'(o_data_valid), 64'd0);
        checkOutput("abort_a_vector", 64'(o_a_vector), 64'd0);
        checkOutput("abort_read_en", 64'(o_read_en), 64'd0);
        checkOutput("abort_pa_reset", 64'(o_pa_reset), 64'd1);
        i_reset = 1'b0;
        valid_seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (o_result_valid || o_busy) valid_seen++;
        end
        checkOutput("abort_no_result", 64'(valid_seen), 64'd0);
    endtask

    // Test sequence
    initial begin
        clearMats();
        i_reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_pa_reset", 64'(o_pa_reset), 64'd1);
        checkOutput("reset_dv", 64'(o_data_valid), 64'd0);
        checkOutput("reset_read_en", 64'(o_read_en), 64'd0);
        checkOutput("reset_valid", 64'(o_result_valid), 64'd0);
        checkOutput("reset_busy", 64'(o_busy), 64'd0);
        i_reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_pa_reset", 64'(o_pa_reset), 64'd0);

        $display("[TB] identity job");
        clearMats();
        mat_a[0][0] = 8'sd1; mat_a[1][1] = 8'sd1;
        mat_b[0][0] = 8'sd1; mat_b[0][1] = 8'sd2;
        mat_b[1][0] = 8'sd3; mat_b[1][1] = 8'sd4;
        applyStimulus(2, 1'b1, 0, 1'b0);
        checkOutput("identity_c", o_result, 64'h0004_0003_0002_0001);

        $display("[TB] saturation job");
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 2; i++) begin
                mat_a[i][k] = 8'sd127;
                mat_b[k][i] = 8'sd127;
            end
        end
        applyStimulus(16, 1'b1, 0, 1'b0);
        checkOutput("sat_c", o_result, 64'h7fff_7fff_7fff_7fff);
        checkOutput("sat_flag", 64'(o_saturate), 64'd1);

        $display("[TB] backpressure and busy-time noise");
        fillRandom();
        applyStimulus(4, 1'b1, 5, 1'b1);
        applyStimulus(4, 1'b0, 0, 1'b0);

        $display("[TB] illegal starts");
        applyIllegalStart(0);
        applyIllegalStart(17);

        $display("[TB] single-element job");
        fillRandom();
        applyStimulus(1, 1'b1, 1, 1'b0);

        $display("[TB] reset mid-stream");
        fillRandom();
        applyAbort();
        fillRandom();
        applyStimulus(8, 1'b1, 2, 1'b0);

        checkOutput("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
